// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path (and the future transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int calc_div(input int clk, input int bps, input int os);
    return clk / (bps * os);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-cycle oversample tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic os_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt     <= '0;
      os_tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      os_tick <= 1'b1;
    end else begin
      cnt     <= cnt + CW'(1);
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver with 3-sample majority vote, parity/framing/overrun
// status and a one-entry valid/ready holding register.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int DIV = calc_div(CLK_FREQ, UART_BPS, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);
  localparam parity_e       PAR_MODE  = parity_e'(PARITY);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_engine: CLK_FREQ too low for UART_BPS*OVERSAMPLE");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_engine: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_engine: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_engine: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_engine: STOP_BITS must be 1 or 2");
  end

  logic os_tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .os_tick (os_tick)
  );

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  logic rxd_meta;
  logic rxd_sync;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  rx_state_e            state;
  logic [SW-1:0]        s;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_acc;
  logic                 frame_err_acc;

  logic vote;
  logic vote_tick;
  logic last_stop;
  logic frame_done;
  logic frame_err_final;
  logic par_expect;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    vote            = majority3(samp[0], samp[1], rxd_sync);
    vote_tick       = os_tick && (s == S_V2);
    last_stop       = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
    frame_done      = vote_tick && (state == ST_STOP) && last_stop;
    frame_err_final = frame_err_acc | ~vote;
    par_expect      = (^shreg) ^ (PAR_MODE == PAR_ODD);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      s             <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      samp          <= '0;
      shreg         <= '0;
      par_err_acc   <= 1'b0;
      frame_err_acc <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      // A completing frame loads only if the slot is free or being emptied this cycle.
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shreg;
          rx_parity_err <= par_err_acc;
          rx_frame_err  <= frame_err_final;
          rx_valid      <= 1'b1;
          rx_overrun    <= 1'b0;
        end else begin
          rx_overrun    <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      if (os_tick) begin
        if (s == S_V0) samp[0] <= rxd_sync;
        if (s == S_V1) samp[1] <= rxd_sync;
        s <= (s == S_LAST) ? '0 : s + SW'(1);

        case (state)
          ST_IDLE: begin
            s <= '0;
            if (!rxd_sync) state <= ST_START;
          end
          ST_START: begin
            if (vote_tick && vote) begin
              state <= ST_IDLE;
              s     <= '0;
            end else if (s == S_LAST) begin
              state         <= ST_DATA;
              bit_cnt       <= '0;
              stop_cnt      <= 1'b0;
              par_err_acc   <= 1'b0;
              frame_err_acc <= 1'b0;
            end
          end
          ST_DATA: begin
            if (vote_tick) begin
              shreg   <= {vote, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end
            if (s == S_LAST && bit_cnt == BITS_LAST)
              state <= (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
          ST_PARITY: begin
            if (vote_tick) par_err_acc <= (vote != par_expect);
            if (s == S_LAST) state <= ST_STOP;
          end
          ST_STOP: begin
            if (vote_tick && !vote) frame_err_acc <= 1'b1;
            // Leave at the last vote rather than the bit end to resync on back-to-back frames.
            if (frame_done) begin
              state <= ST_IDLE;
              s     <= '0;
            end else if (s == S_LAST) begin
              stop_cnt <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            s     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench: 8N1, 8E1 and 7N2 receivers side by side on one clock.
module tb_uart_rx_engine;

  localparam int BIT_CLKS = 432;  // DIV 27 * OVERSAMPLE 16

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #10 sys_clk = ~sys_clk;

  logic       rxd_a, rdy_a, val_a, perr_a, ferr_a, ovr_a;
  logic [7:0] data_a;
  logic       rxd_b, rdy_b, val_b, perr_b, ferr_b, ovr_b;
  logic [7:0] data_b;
  logic       rxd_c, rdy_c, val_c, perr_c, ferr_c, ovr_c;
  logic [6:0] data_c;

  uart_rx_engine u_8n1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd_a), .rx_data(data_a),
    .rx_valid(val_a), .rx_ready(rdy_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .rx_overrun(ovr_a)
  );

  uart_rx_engine #(.PARITY(2)) u_8e1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd_b), .rx_data(data_b),
    .rx_valid(val_b), .rx_ready(rdy_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .rx_overrun(ovr_b)
  );

  uart_rx_engine #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd_c), .rx_data(data_c),
    .rx_valid(val_c), .rx_ready(rdy_c), .rx_parity_err(perr_c),
    .rx_frame_err(ferr_c), .rx_overrun(ovr_c)
  );

  int compared   = 0;
  int mismatched = 0;

  // Handshake monitors: count accepted words and valid-high cycles, keep the last word.
  int hs_a = 0, vcyc_a = 0, hs_b = 0, hs_c = 0;
  logic [7:0] cap_data_a, cap_data_b;
  logic [6:0] cap_data_c;
  logic cap_perr_a, cap_ferr_a, cap_perr_b, cap_ferr_b, cap_ferr_c;

  always @(negedge sys_clk) begin
    if (val_a) vcyc_a++;
    if (val_a && rdy_a) begin
      hs_a++; cap_data_a = data_a; cap_perr_a = perr_a; cap_ferr_a = ferr_a;
    end
    if (val_b && rdy_b) begin
      hs_b++; cap_data_b = data_b; cap_perr_b = perr_b; cap_ferr_b = ferr_b;
    end
    if (val_c && rdy_c) begin
      hs_c++; cap_data_c = data_c; cap_ferr_c = ferr_c;
    end
  end

  task automatic set_line(input int which, input logic v);
    case (which)
      0: rxd_a = v;
      1: rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  task automatic send_bits(input int which, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      set_line(which, bits[i]);
      repeat (BIT_CLKS - 1) @(posedge sys_clk);
    end
    @(posedge sys_clk); #1;
    set_line(which, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(posedge sys_clk);
    @(negedge sys_clk); #1;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    compared++;
    if ({val_a, perr_a, ferr_a, ovr_a, data_a} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_a: got v%b p%b f%b o%b d%h, want all 0", val_a, perr_a, ferr_a, ovr_a, data_a);
    end
    compared++;
    if ({val_b, val_c, data_b, data_c} !== 17'h0) begin
      mismatched++;
      $display("FAIL reset_bc: got vb%b vc%b db%h dc%h, want all 0", val_b, val_c, data_b, data_c);
    end
  endtask

  task automatic test_8n1;
    int hs0, vc0;
    rdy_a = 1'b1;
    hs0 = hs_a; vc0 = vcyc_a;
    send_bits(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
    idle_bits(1);
    compared++;
    if (hs_a - hs0 !== 1 || vcyc_a - vc0 !== 1) begin
      mismatched++;
      $display("FAIL 8n1_pulse: got %0d words / %0d valid cycles, want 1 / 1", hs_a - hs0, vcyc_a - vc0);
    end
    compared++;
    if ({cap_data_a, cap_perr_a, cap_ferr_a} !== {8'hA5, 2'b00}) begin
      mismatched++;
      $display("FAIL 8n1_word: got d%h p%b f%b, want dA5 p0 f0", cap_data_a, cap_perr_a, cap_ferr_a);
    end
  endtask

  task automatic test_break;
    int hs0;
    hs0 = hs_a;
    send_bits(0, 12'h000, 10);
    idle_bits(2);
    compared++;
    if (hs_a - hs0 !== 1 || {cap_data_a, cap_perr_a, cap_ferr_a} !== {8'h00, 2'b01}) begin
      mismatched++;
      $display("FAIL break: got %0d words d%h p%b f%b, want 1 word d00 p0 f1",
               hs_a - hs0, cap_data_a, cap_perr_a, cap_ferr_a);
    end
  endtask

  task automatic test_parity;
    rdy_b = 1'b1;
    send_bits(1, {1'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    idle_bits(1);
    compared++;
    if (hs_b !== 1 || {cap_data_b, cap_perr_b, cap_ferr_b} !== {8'h3C, 2'b10}) begin
      mismatched++;
      $display("FAIL parity_bad: got %0d words d%h p%b f%b, want 1 word d3C p1 f0",
               hs_b, cap_data_b, cap_perr_b, cap_ferr_b);
    end
    send_bits(1, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    idle_bits(1);
    compared++;
    if (hs_b !== 2 || {cap_data_b, cap_perr_b, cap_ferr_b} !== {8'h3C, 2'b00}) begin
      mismatched++;
      $display("FAIL parity_ok: got %0d words d%h p%b f%b, want 2 words d3C p0 f0",
               hs_b, cap_data_b, cap_perr_b, cap_ferr_b);
    end
  endtask

  task automatic test_stop2;
    rdy_c = 1'b1;
    send_bits(2, {2'b00, 1'b0, 1'b1, 7'h55, 1'b0}, 10);
    idle_bits(2);
    compared++;
    if (hs_c !== 1 || {cap_data_c, cap_ferr_c} !== {7'h55, 1'b1}) begin
      mismatched++;
      $display("FAIL stop2_low: got %0d words d%h f%b, want 1 word d55 f1", hs_c, cap_data_c, cap_ferr_c);
    end
    send_bits(2, {2'b00, 1'b1, 1'b1, 7'h2A, 1'b0}, 10);
    idle_bits(2);
    compared++;
    if (hs_c !== 2 || {cap_data_c, cap_ferr_c} !== {7'h2A, 1'b0}) begin
      mismatched++;
      $display("FAIL stop2_ok: got %0d words d%h f%b, want 2 words d2A f0", hs_c, cap_data_c, cap_ferr_c);
    end
  endtask

  task automatic test_glitch;
    int hs0;
    hs0 = hs_a;
    @(posedge sys_clk); #1 rxd_a = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1 rxd_a = 1'b1;
    idle_bits(1);
    compared++;
    if (hs_a !== hs0 || val_a !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_quiet: got %0d words v%b, want 0 words v0", hs_a - hs0, val_a);
    end
    send_bits(0, {2'b00, 1'b1, 8'h81, 1'b0}, 10);
    idle_bits(1);
    compared++;
    if (hs_a - hs0 !== 1 || {cap_data_a, cap_perr_a, cap_ferr_a} !== {8'h81, 2'b00}) begin
      mismatched++;
      $display("FAIL glitch_word: got %0d words d%h p%b f%b, want 1 word d81 p0 f0",
               hs_a - hs0, cap_data_a, cap_perr_a, cap_ferr_a);
    end
  endtask

  task automatic test_back_to_back;
    rdy_a = 1'b0;
    send_bits(0, {2'b00, 1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {2'b00, 1'b1, 8'h22, 1'b0}, 10);
    send_bits(0, {2'b00, 1'b1, 8'h33, 1'b0}, 10);
    idle_bits(1);
    compared++;
    if ({val_a, data_a, ovr_a, ferr_a, perr_a} !== {1'b1, 8'h11, 3'b100}) begin
      mismatched++;
      $display("FAIL b2b_held: got v%b d%h o%b f%b p%b, want v1 d11 o1 f0 p0",
               val_a, data_a, ovr_a, ferr_a, perr_a);
    end
    @(negedge sys_clk); rdy_a = 1'b1;
    @(negedge sys_clk); rdy_a = 1'b0;
    #1;
    compared++;
    if ({val_a, ovr_a} !== 2'b00) begin
      mismatched++;
      $display("FAIL b2b_accept: got v%b o%b, want v0 o0", val_a, ovr_a);
    end
    send_bits(0, {2'b00, 1'b1, 8'h44, 1'b0}, 10);
    idle_bits(1);
    compared++;
    if ({val_a, data_a, ovr_a, ferr_a, perr_a} !== {1'b1, 8'h44, 3'b000}) begin
      mismatched++;
      $display("FAIL b2b_next: got v%b d%h o%b f%b p%b, want v1 d44 o0 f0 p0",
               val_a, data_a, ovr_a, ferr_a, perr_a);
    end
    @(negedge sys_clk); rdy_a = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid;
    int hs0;
    hs0 = hs_a;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1 rxd_a = (i != 0);
      repeat (BIT_CLKS - 1) @(posedge sys_clk);
    end
    @(posedge sys_clk); #2 sys_rst = 1'b1;
    #1;
    compared++;
    if ({val_a, perr_a, ferr_a, ovr_a, data_a} !== 12'h000) begin
      mismatched++;
      $display("FAIL rst_mid: got v%b p%b f%b o%b d%h, want all 0", val_a, perr_a, ferr_a, ovr_a, data_a);
    end
    repeat (3) @(posedge sys_clk);
    #1 rxd_a = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    idle_bits(1);
    send_bits(0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10);
    idle_bits(1);
    compared++;
    if (hs_a - hs0 !== 1 || {cap_data_a, cap_perr_a, cap_ferr_a, ovr_a} !== {8'h5A, 3'b000}) begin
      mismatched++;
      $display("FAIL rst_after: got %0d words d%h p%b f%b o%b, want 1 word d5A p0 f0 o0",
               hs_a - hs0, cap_data_a, cap_perr_a, cap_ferr_a, ovr_a);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_break();
    test_parity();
    test_stop2();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
